// File: rtl/ram_bridge_pkg.sv
// Shared types for the data-RAM request bridge: size codes, FSM states, request source and registered request.
package ram_bridge_pkg;

    localparam int REQ_ADDR_W = 64;
    localparam int REQ_DATA_W = 64;

    typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_D = 2'd3} size_e;
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_e;
    typedef enum logic {SRC_IFU = 1'b0, SRC_LSU = 1'b1} src_e;

    typedef struct packed {
        src_e                  src;
        logic [REQ_ADDR_W-1:0] addr;
        logic                  wen;
        size_e                 size;
        logic                  uns;
        logic [REQ_DATA_W-1:0] wdata;
    } req_t;

    // Only the low three address bits matter for alignment within an 8-byte word.
    function automatic logic misaligned(input logic [2:0] addr, input size_e size);
        unique case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return addr[0] != 1'b0;
            SZ_W:    return addr[1:0] != 2'b00;
            default: return addr != 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/ram_bridge_align.sv
// Combinational lane logic: store byte mask and data shift, load extract/extend, fetch half-word select.
module ram_bridge_align
    import ram_bridge_pkg::*;
#(
    parameter int NUM_LANES = 8,
    parameter int VEC_W     = 8
) (
    input  logic [2:0]                        off,
    input  size_e                             size,
    input  logic                              uns,
    input  logic [NUM_LANES*VEC_W-1:0]        wdata,
    input  logic [NUM_LANES*VEC_W-1:0]        rdata,
    output logic [NUM_LANES-1:0][VEC_W-1:0]   wmask,
    output logic [NUM_LANES*VEC_W-1:0]        wdata_sh,
    output logic [NUM_LANES*VEC_W-1:0]        ldata,
    output logic [31:0]                       inst
);
    localparam int CW = $clog2(NUM_LANES) + 1;

    logic [CW-1:0]              lo;
    logic [CW-1:0]              nbytes;
    logic [NUM_LANES*VEC_W-1:0] raw;

    assign lo     = CW'(off);
    assign nbytes = CW'(1) << size;

    // A lane is written when it falls inside [off, off+nbytes).
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        localparam logic [CW-1:0] LANE = CW'(i);
        assign wmask[i] = ((LANE >= lo) && (LANE < lo + nbytes)) ? '1 : '0;
    end

    assign wdata_sh = wdata << {off, 3'b000};
    assign raw      = rdata >> {off, 3'b000};
    assign inst     = off[2] ? rdata[63:32] : rdata[31:0];

    always_comb begin
        ldata = raw;
        unique case (size)
            SZ_B:    ldata = uns ? {56'b0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
            SZ_H:    ldata = uns ? {48'b0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
            SZ_W:    ldata = uns ? {32'b0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
            default: ldata = raw;
        endcase
    end

endmodule

// File: rtl/ram_req_bridge.sv
// Request front end of the data RAM controller: LSU-priority arbiter, one-deep request register, IDLE/ACCESS/RESP FSM.
module ram_req_bridge
    import ram_bridge_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_req_addr,
    output logic              ifu_resp_valid,
    input  logic              ifu_resp_ready,
    output logic [31:0]       ifu_resp_inst,
    output logic              ifu_resp_misal,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_req_addr,
    input  logic              lsu_req_wen,
    input  logic [1:0]        lsu_req_size,
    input  logic              lsu_req_uns,
    input  logic [DATA_W-1:0] lsu_req_wdata,
    output logic              lsu_resp_valid,
    input  logic              lsu_resp_ready,
    output logic [DATA_W-1:0] lsu_resp_rdata,
    output logic              lsu_resp_misal,
    output logic [ADDR_W-1:0] ram_raddr,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [DATA_W-1:0] ram_wmask,
    output logic              ram_wen
);
    state_e                 state, state_nx;
    req_t                   req;
    logic                   misal, lsu_hs, ifu_hs, wr;
    logic [7:0][7:0]        lane_mask;
    logic [DATA_W-1:0]      wdata_sh, ldata;
    logic [31:0]            inst;

    ram_bridge_align u_align (
        .off      (req.addr[2:0]),
        .size     (req.size),
        .uns      (req.uns),
        .wdata    (req.wdata),
        .rdata    (ram_rdata),
        .wmask    (lane_mask),
        .wdata_sh (wdata_sh),
        .ldata    (ldata),
        .inst     (inst)
    );

    // Fetches are registered as word-sized loads so one alignment rule covers both sources.
    assign misal = misaligned(req.addr[2:0], req.size);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            req   <= '0;
        end else begin
            state <= state_nx;
            if (lsu_hs)
                req <= '{src: SRC_LSU, addr: lsu_req_addr, wen: lsu_req_wen,
                         size: size_e'(lsu_req_size), uns: lsu_req_uns, wdata: lsu_req_wdata};
            else if (ifu_hs)
                req <= '{src: SRC_IFU, addr: ifu_req_addr, wen: 1'b0,
                         size: SZ_W, uns: 1'b0, wdata: '0};
        end
    end

    always_comb begin
        state_nx       = state;
        lsu_req_ready  = 1'b0;
        ifu_req_ready  = 1'b0;
        lsu_resp_valid = 1'b0;
        ifu_resp_valid = 1'b0;
        wr             = 1'b0;

        unique case (state)
            IDLE: begin
                // Gated by reset_n so nothing looks accepted while reset is held.
                lsu_req_ready = reset_n;
                ifu_req_ready = reset_n & ~lsu_req_valid;
                if (lsu_req_valid || ifu_req_valid)
                    state_nx = ACCESS;
            end
            ACCESS: begin
                wr       = req.wen & ~misal;
                state_nx = RESP;
            end
            RESP: begin
                lsu_resp_valid = (req.src == SRC_LSU);
                ifu_resp_valid = (req.src == SRC_IFU);
                if ((req.src == SRC_LSU) ? lsu_resp_ready : ifu_resp_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        lsu_hs = lsu_req_valid & lsu_req_ready;
        ifu_hs = ifu_req_valid & ifu_req_ready;

        ram_raddr      = {req.addr[ADDR_W-1:3], 3'b000};
        ram_waddr      = {req.addr[ADDR_W-1:3], 3'b000};
        ram_wen        = wr;
        ram_wmask      = wr ? DATA_W'(lane_mask) : '0;
        ram_wdata      = wr ? wdata_sh : '0;
        lsu_resp_misal = lsu_resp_valid & misal;
        lsu_resp_rdata = (lsu_resp_valid & ~misal & ~req.wen) ? ldata : '0;
        ifu_resp_misal = ifu_resp_valid & misal;
        ifu_resp_inst  = (ifu_resp_valid & ~misal) ? inst : '0;
    end

endmodule

// File: tb/tb_ram_req_bridge.sv
// Bench for ram_req_bridge: 512-byte RAM window, byte-level reference memory, directed plus random requests.
module tb_ram_req_bridge;
    localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        ifu_req_valid = 0, ifu_req_ready, ifu_resp_valid, ifu_resp_ready = 0, ifu_resp_misal;
    logic [63:0] ifu_req_addr = 0;
    logic [31:0] ifu_resp_inst;
    logic        lsu_req_valid = 0, lsu_req_ready, lsu_req_wen = 0, lsu_req_uns = 0;
    logic [1:0]  lsu_req_size = 0;
    logic [63:0] lsu_req_addr = 0, lsu_req_wdata = 0, lsu_resp_rdata;
    logic        lsu_resp_valid, lsu_resp_ready = 0, lsu_resp_misal;
    logic [63:0] ram_raddr, ram_rdata, ram_waddr, ram_wdata, ram_wmask;
    logic        ram_wen;

    int errors = 0, checks = 0, wen_cycles = 0;
    logic [63:0] last_rdata, last_wmask, last_wdata;
    logic        last_misal;

    logic [63:0] ram [0:63];
    logic [7:0]  ref_mem [0:511];

    always #5 clock = ~clock;

    ram_req_bridge dut (
        .clock(clock), .reset_n(reset_n),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
        .ifu_resp_inst(ifu_resp_inst), .ifu_resp_misal(ifu_resp_misal),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
        .lsu_req_wen(lsu_req_wen), .lsu_req_size(lsu_req_size), .lsu_req_uns(lsu_req_uns),
        .lsu_req_wdata(lsu_req_wdata), .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
        .lsu_resp_rdata(lsu_resp_rdata), .lsu_resp_misal(lsu_resp_misal),
        .ram_raddr(ram_raddr), .ram_rdata(ram_rdata), .ram_waddr(ram_waddr),
        .ram_wdata(ram_wdata), .ram_wmask(ram_wmask), .ram_wen(ram_wen)
    );

    // RAM: registered read of the word addressed at the edge, masked write at the same edge.
    always @(posedge clock) begin
        ram_rdata <= ram[ram_raddr[8:3]];
        if (ram_wen)
            ram[ram_waddr[8:3]] <= (ram[ram_waddr[8:3]] & ~ram_wmask) | (ram_wdata & ram_wmask);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Per-cycle invariants, sampled away from the active edge.
    always @(negedge clock) begin
        if (reset_n) begin
            checks++;
            if ((ifu_resp_valid && lsu_resp_valid) || (ram_wen && ram_wmask == 64'h0)) begin
                errors++;
                $display("FAIL monitor: ifu_v=%0b lsu_v=%0b wen=%0b wmask=%h",
                         ifu_resp_valid, lsu_resp_valid, ram_wen, ram_wmask);
            end
            if (ram_wen) wen_cycles++;
        end
    end

    function automatic logic [63:0] model_read(input logic [63:0] a, input int n, input bit uns);
        logic [63:0] v = 64'h0;
        for (int b = 0; b < n; b++) v |= 64'(ref_mem[int'(a[8:0]) + b]) << (8 * b);
        if (!uns && n < 8 && v[8*n-1]) v |= ~64'h0 << (8 * n);
        return v;
    endfunction

    // One complete request: handshake, ACCESS checks, RESP held for 'hold' cycles, release.
    task automatic req(input bit lsu, input logic [63:0] a, input bit wen, input logic [1:0] sz,
                       input bit uns, input logic [63:0] wd, input int hold);
        int n, off, guard, wen0;
        bit mis, wr;
        logic [63:0] exp_d, exp_m;
        n     = lsu ? (1 << sz) : 4;
        off   = int'(a[2:0]);
        mis   = (a % 64'(n)) != 0;
        wr    = lsu && wen && !mis;
        exp_d = (mis || (lsu && wen)) ? 64'h0 : model_read(a, n, lsu ? uns : 1'b1);
        exp_m = 64'h0;
        for (int b = 0; b < n; b++) exp_m |= 64'hFF << (8 * (off + b));
        if (lsu) begin
            lsu_req_valid = 1; lsu_req_addr = a; lsu_req_wen = wen;
            lsu_req_size = sz; lsu_req_uns = uns; lsu_req_wdata = wd;
        end else begin
            ifu_req_valid = 1; ifu_req_addr = a;
        end
        #1;
        guard = 0;
        while (!(lsu ? lsu_req_ready : ifu_req_ready) && guard < 20) begin
            @(posedge clock); #1; guard++;
        end
        if (guard >= 20) begin
            checks++; errors++;
            $display("FAIL handshake_timeout: src_lsu=%0b addr=%h", lsu, a);
            lsu_req_valid = 0; ifu_req_valid = 0;
            return;
        end
        wen0 = wen_cycles;
        @(posedge clock); #1;
        if (lsu) begin
            lsu_req_valid = 0; lsu_req_addr = {$urandom, $urandom}; lsu_req_wen = 1'($urandom);
            lsu_req_size = 2'($urandom); lsu_req_uns = 1'($urandom); lsu_req_wdata = {$urandom, $urandom};
        end else begin
            ifu_req_valid = 0; ifu_req_addr = {$urandom, $urandom};
        end
        if (wr) for (int b = 0; b < n; b++) ref_mem[int'(a[8:0]) + b] = wd[8*b +: 8];
        chk("access_resp_valid", 64'({ifu_resp_valid, lsu_resp_valid}), 64'h0);
        chk("access_wen", 64'(ram_wen), 64'(wr));
        chk("access_raddr", ram_raddr, a & ~64'h7);
        if (wr) begin
            chk("access_waddr", ram_waddr, a & ~64'h7);
            chk("access_wmask", ram_wmask, exp_m);
            chk("access_wdata", ram_wdata, wd << (8 * off));
        end else begin
            chk("access_wmask_zero", ram_wmask, 64'h0);
        end
        last_wmask = ram_wmask;
        last_wdata = ram_wdata;
        for (int c = 0; c <= hold; c++) begin
            if (lsu) ifu_resp_ready = 1'($urandom); else lsu_resp_ready = 1'($urandom);
            @(posedge clock); #1;
            chk("resp_wen", 64'(ram_wen), 64'h0);
            if (lsu) begin
                chk("lsu_resp_valid", 64'({ifu_resp_valid, lsu_resp_valid}), 64'h1);
                chk("lsu_resp_rdata", lsu_resp_rdata, exp_d);
                chk("lsu_resp_misal", 64'(lsu_resp_misal), 64'(mis));
                last_rdata = lsu_resp_rdata; last_misal = lsu_resp_misal;
            end else begin
                chk("ifu_resp_valid", 64'({ifu_resp_valid, lsu_resp_valid}), 64'h2);
                chk("ifu_resp_inst", 64'(ifu_resp_inst), exp_d);
                chk("ifu_resp_misal", 64'(ifu_resp_misal), 64'(mis));
                last_rdata = 64'(ifu_resp_inst); last_misal = ifu_resp_misal;
            end
            if (c == hold) begin
                if (lsu) lsu_resp_ready = 1; else ifu_resp_ready = 1;
            end
        end
        @(posedge clock); #1;
        lsu_resp_ready = 0; ifu_resp_ready = 0;
        chk("released_valid", 64'({ifu_resp_valid, lsu_resp_valid}), 64'h0);
        chk("released_idle", 64'(lsu_req_ready), 64'h1);
        chk("store_write_count", 64'(wen_cycles - wen0), 64'(wr));
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            logic [63:0] w;
            w = (i == 0) ? 64'hDEAD_BEEF_CAFE_F00D : {$urandom, $urandom};
            ram[i] = w;
            for (int b = 0; b < 8; b++) ref_mem[i*8 + b] = w[8*b +: 8];
        end
        repeat (2) @(posedge clock);
        #1;
        chk("reset_lsu_ready", 64'(lsu_req_ready), 64'h0);
        chk("reset_ifu_ready", 64'(ifu_req_ready), 64'h0);
        chk("reset_resp", 64'({ifu_resp_valid, lsu_resp_valid, ram_wen}), 64'h0);
        chk("reset_ram_out", ram_raddr | ram_waddr | ram_wdata | ram_wmask, 64'h0);
        @(negedge clock) reset_n = 1;
        @(posedge clock); #1;

        req(1, BASE + 64'h10, 1, 2'd3, 0, 64'h1122_3344_5566_7788, 0);
        chk("sd_wmask_lit", last_wmask, 64'hFFFF_FFFF_FFFF_FFFF);
        req(1, BASE + 64'h10, 0, 2'd3, 0, 64'h0, 0);
        chk("ld_lit", last_rdata, 64'h1122_3344_5566_7788);
        req(1, BASE + 64'h13, 1, 2'd0, 0, 64'hAB, 0);
        chk("sb_wmask_lit", last_wmask, 64'h0000_0000_FF00_0000);
        chk("sb_wdata_lit", last_wdata, 64'h0000_0000_AB00_0000);
        req(1, BASE + 64'h13, 0, 2'd0, 0, 64'h0, 0);
        chk("lb_lit", last_rdata, 64'hFFFF_FFFF_FFFF_FFAB);
        req(1, BASE + 64'h13, 0, 2'd0, 1, 64'h0, 0);
        chk("lbu_lit", last_rdata, 64'h0000_0000_0000_00AB);

        // Simultaneous requests: LSU wins, IFU waits and follows.
        ifu_req_valid = 1; ifu_req_addr = BASE + 64'h4;
        lsu_req_valid = 1; lsu_req_addr = BASE + 64'h10; lsu_req_wen = 0; lsu_req_size = 2'd3;
        #1;
        chk("both_ifu_ready", 64'(ifu_req_ready), 64'h0);
        chk("both_lsu_ready", 64'(lsu_req_ready), 64'h1);
        req(1, BASE + 64'h10, 0, 2'd3, 0, 64'h0, 1);
        req(0, BASE + 64'h4, 0, 2'd2, 0, 64'h0, 0);
        chk("fetch_hi_lit", last_rdata, 64'hDEAD_BEEF);

        req(1, BASE + 64'h2, 0, 2'd2, 0, 64'h0, 0);
        chk("lw_misal_lit", 64'({last_misal, last_rdata == 64'h0}), 64'h3);
        req(1, BASE + 64'h2, 1, 2'd2, 0, 64'hFFFF_FFFF, 0);
        req(0, BASE + 64'h1, 0, 2'd2, 0, 64'h0, 0);
        chk("ifu_misal_lit", 64'({last_misal, last_rdata == 64'h0}), 64'h3);
        req(1, BASE + 64'h18, 1, 2'd3, 0, 64'h0F0E_0D0C_0B0A_0908, 5);
        req(1, BASE + 64'h18, 0, 2'd1, 0, 64'h0, 5);

        // Reset during ACCESS of a store: nothing written, no response.
        lsu_req_valid = 1; lsu_req_addr = BASE + 64'h20; lsu_req_wen = 1;
        lsu_req_size = 2'd3; lsu_req_wdata = 64'h5555_AAAA_5555_AAAA;
        #1;
        chk("rst_pre_ready", 64'(lsu_req_ready), 64'h1);
        @(posedge clock); #1;
        lsu_req_valid = 0;
        chk("rst_access_wen", 64'(ram_wen), 64'h1);
        reset_n = 0;
        #1;
        chk("rst_async_wen", 64'({ram_wen, lsu_resp_valid, ifu_resp_valid, lsu_req_ready, ifu_req_ready}), 64'h0);
        chk("rst_async_ram", ram_raddr | ram_waddr | ram_wdata | ram_wmask | lsu_resp_rdata, 64'h0);
        @(posedge clock);
        @(negedge clock) reset_n = 1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clock); #1;
            chk("rst_no_resp", 64'({lsu_resp_valid, ifu_resp_valid}), 64'h0);
        end
        req(1, BASE + 64'h20, 0, 2'd3, 0, 64'h0, 0);

        for (int i = 0; i < 150; i++) begin
            logic [63:0] a;
            logic [1:0]  sz;
            bit          lsu;
            lsu = 1'($urandom);
            sz  = lsu ? 2'($urandom) : 2'd2;
            a   = BASE + 64'($urandom_range(0, 511));
            if ($urandom_range(0, 3) != 0) a &= ~64'((1 << sz) - 1);
            req(lsu, a, lsu && 1'($urandom), sz, 1'($urandom), {$urandom, $urandom}, $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
